// File: rtl/fifo_pkg.sv
// Shared pointer type and Gray-code helpers for the async FIFO write and read sides.
// The pointer type is one bit wider than the address so that full and empty can be told apart.
package fifo_pkg;

   localparam int PTR_WIDTH = 6;
   localparam int DEPTH     = 2**PTR_WIDTH;

   typedef logic [PTR_WIDTH:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t ptr);
      return ptr ^ (ptr >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic ptr_t gray2bin(input ptr_t ptr);
      ptr_t bin;
      bin[PTR_WIDTH] = ptr[PTR_WIDTH];
      for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ ptr[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_gray_cnt.sv
// Binary + Gray pointer register pair with increment enable.
// The read-side empty generator reuses this counter.
module fifo_gray_cnt
   import fifo_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 inc_i,
   output logic [PTR_WIDTH-1:0] addr_o,
   output ptr_t                 bin_next_o,
   output ptr_t                 gray_o
);

   ptr_t binQ_q;
   ptr_t binQ_d;
   ptr_t grayQ_q;
   ptr_t grayQ_d;

   // The Gray value is registered rather than decoded so the cross-domain pointer never glitches.
   always_comb begin
      binQ_d  = inc_i ? binQ_q + ptr_t'(1) : binQ_q;
      grayQ_d = bin2gray(binQ_d);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         binQ_q  <= '0;
         grayQ_q <= '0;
      end else begin
         binQ_q  <= binQ_d;
         grayQ_q <= grayQ_d;
      end
   end

   assign addr_o     = binQ_q[PTR_WIDTH-1:0];
   assign bin_next_o = binQ_d;
   assign gray_o     = grayQ_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag generator of the async FIFO.
// Define FIFO_ALMOST_FULL_EN to add the registered almost_full flag (threshold AF_THRESH).
module fifo_wptr_full #(
   parameter int PTR_WIDTH = 6
`ifdef FIFO_ALMOST_FULL_EN
   ,
   parameter int AF_THRESH = 60
`endif
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 wr_en,
   input  logic [PTR_WIDTH:0]   rptr_gray_sync,
   output logic [PTR_WIDTH-1:0] waddr,
   output logic                 wr_accept,
   output logic [PTR_WIDTH:0]   wptr_gray,
   output logic                 full,
   output logic                 overflow,
   output logic                 almost_full
);

   import fifo_pkg::*;

   ptr_t wbinNext;
   ptr_t rqFull;
   logic full_q;
   logic full_d;
   logic overflow_q;
   logic overflow_d;

   assign wr_accept = wr_en & ~full_q;

   fifo_gray_cnt u_wcnt (
      .clk        (clk),
      .resetn     (resetn),
      .inc_i      (wr_accept),
      .addr_o     (waddr),
      .bin_next_o (wbinNext),
      .gray_o     (wptr_gray)
   );

   // Full when the next write pointer sits exactly one lap ahead of the synchronized read pointer.
   always_comb begin
      rqFull     = {~rptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1], rptr_gray_sync[PTR_WIDTH-2:0]};
      full_d     = (bin2gray(wbinNext) == rqFull);
      overflow_d = overflow_q | (wr_en & full_q);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   assign full     = full_q;
   assign overflow = overflow_q;

`ifdef FIFO_ALMOST_FULL_EN
   ptr_t rqBin;
   ptr_t levelNext;
   logic almostFull_q;
   logic almostFull_d;

   // Fill level wraps naturally in the pointer width since it never exceeds the depth.
   always_comb begin
      rqBin        = gray2bin(rptr_gray_sync);
      levelNext    = wbinNext - rqBin;
      almostFull_d = (levelNext >= ptr_t'(AF_THRESH));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         almostFull_q <= 1'b0;
      end else begin
         almostFull_q <= almostFull_d;
      end
   end

   assign almost_full = almostFull_q;
`else
   assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full against a word-count model of the write side.
// Honours FIFO_ALMOST_FULL_EN the same way as the design.
module tb_fifo_wptr_full;

   localparam int PW    = 6;
   localparam int DEPTH = 64;
   localparam int MOD   = 128;
   localparam int AF    = 60;
`ifdef FIFO_ALMOST_FULL_EN
   localparam bit AF_ON = 1'b1;
`else
   localparam bit AF_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          wr_en = 1'b0;
   logic [PW:0]   rq = '0;
   logic [PW-1:0] waddr;
   logic          wr_accept;
   logic [PW:0]   wptr_gray;
   logic          full;
   logic          overflow;
   logic          almost_full;

   fifo_wptr_full #(.PTR_WIDTH(PW)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .wr_en          (wr_en),
      .rptr_gray_sync (rq),
      .waddr          (waddr),
      .wr_accept      (wr_accept),
      .wptr_gray      (wptr_gray),
      .full           (full),
      .overflow       (overflow),
      .almost_full    (almost_full)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: write count and read count modulo twice the depth, plus flags.
   int            mWptr = 0;
   int            rRead = 0;
   bit            mFull = 1'b0;
   bit            mOverflow = 1'b0;
   bit            mAf = 1'b0;
   bit            expAccept;
   logic          obsAccept;
   logic [PW-1:0] obsWaddrPre;

   function automatic logic [PW:0] toGray(input int b);
      logic [PW:0] v;
      v = b[PW:0];
      return v ^ (v >> 1);
   endfunction

   function automatic int levelOf(input int w, input int r);
      return (w - r + MOD) % MOD;
   endfunction

   task automatic modelReset();
      mWptr     = 0;
      mFull     = 1'b0;
      mOverflow = 1'b0;
      mAf       = 1'b0;
   endtask

   // Drive one cycle at the falling edge, sample the comb strobe, then advance the model at the edge.
   task automatic applyStimulus(input bit we, input int rcnt);
      int lvl;
      @(negedge clk);
      wr_en = we;
      rRead = rcnt % MOD;
      rq    = toGray(rRead);
      #1;
      obsAccept   = wr_accept;
      obsWaddrPre = waddr;
      expAccept   = we && !mFull;
      @(posedge clk);
      if (expAccept) mWptr = (mWptr + 1) % MOD;
      else if (we) mOverflow = 1'b1;
      lvl   = levelOf(mWptr, rRead);
      mFull = (lvl == DEPTH);
      mAf   = AF_ON && (lvl >= AF);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      wr_en  = 1'b1;
      rq     = 7'($urandom_range(0, MOD - 1));
      repeat (3) @(posedge clk);
      #1;
      checks++; if (waddr !== 6'd0) begin errors++; $display("[TB] FAIL reset_waddr got=%0d exp=0", waddr); end
      checks++; if (wptr_gray !== 7'd0) begin errors++; $display("[TB] FAIL reset_gray got=%b exp=0000000", wptr_gray); end
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_af got=%b exp=0", almost_full); end
      @(negedge clk);
      wr_en  = 1'b0;
      rq     = '0;
      rRead  = 0;
      resetn = 1'b1;
      modelReset();
   endtask

   task automatic test_fill();
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(1'b1, 0);
         checks++; if (obsAccept !== 1'b1) begin errors++; $display("[TB] FAIL fill_accept push=%0d got=%b exp=1", i, obsAccept); end
         checks++; if (waddr !== 6'(mWptr % DEPTH)) begin errors++; $display("[TB] FAIL fill_waddr push=%0d got=%0d exp=%0d", i, waddr, mWptr % DEPTH); end
         checks++; if (full !== mFull) begin errors++; $display("[TB] FAIL fill_full push=%0d got=%b exp=%b", i, full, mFull); end
         if (i == AF - 1) begin
            checks++; if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL af_below push=%0d got=%b exp=0", i, almost_full); end
         end
         if (i == AF) begin
            checks++; if (almost_full !== AF_ON) begin errors++; $display("[TB] FAIL af_at push=%0d got=%b exp=%b", i, almost_full, AF_ON); end
         end
      end
      checks++; if (wptr_gray !== 7'b1100000) begin errors++; $display("[TB] FAIL fill_gray got=%b exp=1100000", wptr_gray); end
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full_final got=%b exp=1", full); end
   endtask

   task automatic test_push_while_full();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 0);
         checks++; if (obsAccept !== 1'b0) begin errors++; $display("[TB] FAIL pwf_accept cyc=%0d got=%b exp=0", i, obsAccept); end
         checks++; if (waddr !== 6'd0) begin errors++; $display("[TB] FAIL pwf_waddr cyc=%0d got=%0d exp=0", i, waddr); end
         checks++; if (wptr_gray !== 7'b1100000) begin errors++; $display("[TB] FAIL pwf_gray cyc=%0d got=%b exp=1100000", i, wptr_gray); end
         checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL pwf_overflow cyc=%0d got=%b exp=1", i, overflow); end
      end
      applyStimulus(1'b0, 0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_release();
      applyStimulus(1'b0, 1);
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL release_full got=%b exp=0", full); end
      applyStimulus(1'b1, 1);
      checks++; if (obsAccept !== 1'b1) begin errors++; $display("[TB] FAIL release_accept got=%b exp=1", obsAccept); end
      checks++; if (obsWaddrPre !== 6'd0) begin errors++; $display("[TB] FAIL release_waddr got=%0d exp=0", obsWaddrPre); end
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL release_refull got=%b exp=1", full); end
   endtask

   task automatic test_wrap();
      bit sawTop  = 1'b0;
      bit sawZero = 1'b0;
      int fullSeen = 0;
      applyStimulus(1'b0, mWptr - 1 + MOD);
      for (int i = 0; i < MOD; i++) begin
         applyStimulus(1'b1, mWptr - 1 + MOD);
         checks++; if (wptr_gray !== toGray(mWptr)) begin errors++; $display("[TB] FAIL wrap_gray cyc=%0d got=%b exp=%b", i, wptr_gray, toGray(mWptr)); end
         if (full !== 1'b0) fullSeen++;
         if (mWptr == MOD - 1 && wptr_gray === 7'b1000000) sawTop = 1'b1;
         if (sawTop && mWptr == 0 && wptr_gray === 7'b0000000) sawZero = 1'b1;
      end
      checks++; if (sawTop !== 1'b1) begin errors++; $display("[TB] FAIL wrap_top got=%b exp=1", sawTop); end
      checks++; if (sawZero !== 1'b1) begin errors++; $display("[TB] FAIL wrap_zero got=%b exp=1", sawZero); end
      checks++; if (fullSeen != 0) begin errors++; $display("[TB] FAIL wrap_nofull got=%0d exp=0", fullSeen); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int  lvl;
         int  rNext;
         bit  we;
         lvl   = levelOf(mWptr, rRead);
         rNext = rRead + ((lvl > 0 && $urandom_range(0, 2) == 0) ? 1 : 0);
         we    = ($urandom_range(0, 3) != 0);
         applyStimulus(we, rNext);
         checks++; if (obsAccept !== expAccept) begin errors++; $display("[TB] FAIL rnd_accept cyc=%0d got=%b exp=%b", i, obsAccept, expAccept); end
         checks++; if (waddr !== 6'(mWptr % DEPTH)) begin errors++; $display("[TB] FAIL rnd_waddr cyc=%0d got=%0d exp=%0d", i, waddr, mWptr % DEPTH); end
         checks++; if (wptr_gray !== toGray(mWptr)) begin errors++; $display("[TB] FAIL rnd_gray cyc=%0d got=%b exp=%b", i, wptr_gray, toGray(mWptr)); end
         checks++; if (full !== mFull) begin errors++; $display("[TB] FAIL rnd_full cyc=%0d got=%b exp=%b", i, full, mFull); end
         checks++; if (overflow !== mOverflow) begin errors++; $display("[TB] FAIL rnd_overflow cyc=%0d got=%b exp=%b", i, overflow, mOverflow); end
         checks++; if (almost_full !== mAf) begin errors++; $display("[TB] FAIL rnd_af cyc=%0d got=%b exp=%b", i, almost_full, mAf); end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, rRead);
      @(negedge clk);
      #2;
      wr_en  = 1'b1;
      resetn = 1'b0;
      #1;
      checks++; if (waddr !== 6'd0) begin errors++; $display("[TB] FAIL mid_waddr got=%0d exp=0", waddr); end
      checks++; if (wptr_gray !== 7'd0) begin errors++; $display("[TB] FAIL mid_gray got=%b exp=0000000", wptr_gray); end
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL mid_full got=%b exp=0", full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow got=%b exp=0", overflow); end
      @(posedge clk);
      #1;
      checks++; if (wptr_gray !== 7'd0) begin errors++; $display("[TB] FAIL mid_hold_gray got=%b exp=0000000", wptr_gray); end
      @(negedge clk);
      wr_en  = 1'b0;
      rq     = '0;
      rRead  = 0;
      resetn = 1'b1;
      modelReset();
      applyStimulus(1'b1, 0);
      checks++; if (obsWaddrPre !== 6'd0) begin errors++; $display("[TB] FAIL mid_first_waddr got=%0d exp=0", obsWaddrPre); end
      checks++; if (wptr_gray !== 7'b0000001) begin errors++; $display("[TB] FAIL mid_first_gray got=%b exp=0000001", wptr_gray); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_fill();
      test_push_while_full();
      test_release();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
